// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: serialises a 6-byte SPI command frame through the byte engine,
// then polls response bytes until a valid R1 (bit7 clear) arrives or the poll limit expires.
module sd_cmd_sequencer #(
   parameter int unsigned POLL_MAX = 8
) (
   input  logic        CLK50,
   input  logic        RST,
   input  logic        CMD_STB,
   input  logic [5:0]  CMD_IDX,
   input  logic [31:0] CMD_ARG,
   input  logic [6:0]  CMD_CRC,
   output logic        BUSY,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_R1,
   output logic        RSP_TIMEOUT,
   output logic        SPI_W_STB,
   output logic [7:0]  SPI_W_DATA,
   output logic        SPI_R_STB,
   input  logic [7:0]  SPI_R_DATA,
   input  logic        SPI_DONE
);

   localparam int unsigned IDX_W  = 6;
   localparam int unsigned ARG_W  = 32;
   localparam int unsigned CRC_W  = 7;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned BIDX_W = 3;

   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(5);
   localparam logic [CNT_W-1:0]  POLL_LIM  = CNT_W'(POLL_MAX);
   localparam logic [BYTE_W-1:0] R1_NONE   = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_W,
      S_POLL,
      S_WAIT_R,
      S_FIN
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ARG_W-1:0]    arg_q, arg_d;
   logic [CRC_W-1:0]    crc_q, crc_d;
   logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]    poll_cnt_q, poll_cnt_d;
   logic                busy_q, busy_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [BYTE_W-1:0]   rsp_r1_q, rsp_r1_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                w_stb_q, w_stb_d;
   logic [BYTE_W-1:0]   w_data_q, w_data_d;
   logic                r_stb_q, r_stb_d;

   // Byte 'sel' of the command frame: start/transmit bits, index, argument MSB first, CRC7 + end bit.
   function automatic logic [BYTE_W-1:0] frame_byte(
      input logic [BIDX_W-1:0] sel,
      input logic [IDX_W-1:0]  idx,
      input logic [ARG_W-1:0]  arg,
      input logic [CRC_W-1:0]  crc
   );
      logic [BYTE_W-1:0] b;
      case (sel)
         BIDX_W'(0): b = {2'b01, idx};
         BIDX_W'(1): b = arg[31:24];
         BIDX_W'(2): b = arg[23:16];
         BIDX_W'(3): b = arg[15:8];
         BIDX_W'(4): b = arg[7:0];
         BIDX_W'(5): b = {crc, 1'b1};
         default:    b = 8'hFF;
      endcase
      return b;
   endfunction

   // Next-state and registered-output logic; strobes are raised on entry to SEND/POLL.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      arg_d         = arg_q;
      crc_d         = crc_q;
      byte_idx_d    = byte_idx_q;
      poll_cnt_d    = poll_cnt_q;
      busy_d        = busy_q;
      rsp_valid_d   = 1'b0;
      rsp_r1_d      = rsp_r1_q;
      rsp_timeout_d = rsp_timeout_q;
      w_stb_d       = 1'b0;
      w_data_d      = w_data_q;
      r_stb_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (CMD_STB) begin
               idx_d      = CMD_IDX;
               arg_d      = CMD_ARG;
               crc_d      = CMD_CRC;
               byte_idx_d = '0;
               poll_cnt_d = '0;
               busy_d     = 1'b1;
               w_stb_d    = 1'b1;
               w_data_d   = frame_byte(BIDX_W'(0), CMD_IDX, CMD_ARG, CMD_CRC);
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_WAIT_W;
         end
         S_WAIT_W: begin
            if (SPI_DONE) begin
               if (byte_idx_q == LAST_BYTE) begin
                  r_stb_d = 1'b1;
                  state_d = S_POLL;
               end else begin
                  byte_idx_d = byte_idx_q + BIDX_W'(1);
                  w_stb_d    = 1'b1;
                  w_data_d   = frame_byte(byte_idx_q + BIDX_W'(1), idx_q, arg_q, crc_q);
                  state_d    = S_SEND;
               end
            end
         end
         S_POLL: begin
            poll_cnt_d = poll_cnt_q + CNT_W'(1);
            state_d    = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (SPI_DONE) begin
               if (!SPI_R_DATA[7]) begin
                  rsp_r1_d      = SPI_R_DATA;
                  rsp_timeout_d = 1'b0;
                  rsp_valid_d   = 1'b1;
                  state_d       = S_FIN;
               end else if (poll_cnt_q == POLL_LIM) begin
                  rsp_r1_d      = R1_NONE;
                  rsp_timeout_d = 1'b1;
                  rsp_valid_d   = 1'b1;
                  state_d       = S_FIN;
               end else begin
                  r_stb_d = 1'b1;
                  state_d = S_POLL;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK50 or negedge RST) begin
      if (!RST) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         arg_q         <= '0;
         crc_q         <= '0;
         byte_idx_q    <= '0;
         poll_cnt_q    <= '0;
         busy_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_r1_q      <= '0;
         rsp_timeout_q <= 1'b0;
         w_stb_q       <= 1'b0;
         w_data_q      <= '0;
         r_stb_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         arg_q         <= arg_d;
         crc_q         <= crc_d;
         byte_idx_q    <= byte_idx_d;
         poll_cnt_q    <= poll_cnt_d;
         busy_q        <= busy_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_r1_q      <= rsp_r1_d;
         rsp_timeout_q <= rsp_timeout_d;
         w_stb_q       <= w_stb_d;
         w_data_q      <= w_data_d;
         r_stb_q       <= r_stb_d;
      end
   end

   assign BUSY        = busy_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_R1      = rsp_r1_q;
   assign RSP_TIMEOUT = rsp_timeout_q;
   assign SPI_W_STB   = w_stb_q;
   assign SPI_W_DATA  = w_data_q;
   assign SPI_R_STB   = r_stb_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: SPI engine model with configurable latency, frame/response
// model built from the command fields, and a per-cycle monitor comparing the DUT against it.
module tb_sd_cmd_sequencer;

   localparam int unsigned POLL_MAX = 8;

   logic        CLK50 = 1'b0;
   logic        RST = 1'b1;
   logic        CMD_STB = 1'b0;
   logic [5:0]  CMD_IDX = '0;
   logic [31:0] CMD_ARG = '0;
   logic [6:0]  CMD_CRC = '0;
   logic        BUSY, RSP_VALID, RSP_TIMEOUT, SPI_W_STB, SPI_R_STB;
   logic [7:0]  RSP_R1, SPI_W_DATA;
   logic [7:0]  SPI_R_DATA = '0;
   logic        SPI_DONE = 1'b0;

   sd_cmd_sequencer #(.POLL_MAX(POLL_MAX)) dut (
      .CLK50(CLK50), .RST(RST),
      .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG), .CMD_CRC(CMD_CRC),
      .BUSY(BUSY), .RSP_VALID(RSP_VALID), .RSP_R1(RSP_R1), .RSP_TIMEOUT(RSP_TIMEOUT),
      .SPI_W_STB(SPI_W_STB), .SPI_W_DATA(SPI_W_DATA), .SPI_R_STB(SPI_R_STB),
      .SPI_R_DATA(SPI_R_DATA), .SPI_DONE(SPI_DONE)
   );

   always #5 CLK50 = ~CLK50;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input bit ok, input string name, input longint unsigned act,
                        input longint unsigned exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model state
   logic [7:0] exp_w[$];
   logic [7:0] rd_src[$];
   logic [7:0] eng_rd[$];
   logic [7:0] wlog[$];
   int         strobe_cyc[$];
   int         exp_reads, writes_seen, reads_seen, valid_seen, busy_cycles;
   logic [7:0] exp_r1, last_r1 = '0, last_w = '0;
   logic       exp_to, last_to = 1'b0;
   bit         mdl_busy = 1'b0;
   int         cyc = 0, acc_cyc = 0, done_cyc = -10;
   int         eng_lat = 2;

   // Acceptance model: a command is taken exactly when the sequencer is not busy.
   always @(posedge CLK50 or negedge RST) begin
      if (!RST) mdl_busy <= 1'b0;
      else begin
         if (mdl_busy && RSP_VALID) mdl_busy <= 1'b0;
         else if (!mdl_busy && CMD_STB) begin
            mdl_busy <= 1'b1;
            acc_cyc  <= cyc;
         end
         cyc <= cyc + 1;
      end
   end

   // SPI byte engine: DONE eng_lat cycles after each strobe, read data from eng_rd (else 0xFF).
   initial begin
      forever begin
         @(negedge CLK50);
         if (RST && (SPI_W_STB || SPI_R_STB)) begin
            automatic bit is_rd = SPI_R_STB;
            repeat (eng_lat) @(posedge CLK50);
            #1;
            SPI_DONE = 1'b1;
            done_cyc = cyc;
            if (is_rd) SPI_R_DATA = (eng_rd.size() > 0) ? eng_rd.pop_front() : 8'hFF;
            else       SPI_R_DATA = 8'h00;
            @(posedge CLK50);
            #1;
            SPI_DONE   = 1'b0;
            SPI_R_DATA = 8'h00;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge CLK50) begin
      if (!RST) begin
         check({BUSY, RSP_VALID, RSP_TIMEOUT, SPI_W_STB, SPI_R_STB, RSP_R1, SPI_W_DATA} == '0,
               "reset_outs", {BUSY, RSP_VALID, RSP_TIMEOUT, SPI_W_STB, SPI_R_STB, RSP_R1, SPI_W_DATA}, 0);
         last_r1 = '0; last_to = 1'b0; last_w = '0;
      end else begin
         check(BUSY == mdl_busy, "busy", BUSY, mdl_busy);
         if (BUSY) busy_cycles++;
         check(!(SPI_W_STB && SPI_R_STB), "strobe_overlap", {SPI_W_STB, SPI_R_STB}, 0);
         if (SPI_W_STB) begin
            if (writes_seen == 0) check(cyc == acc_cyc + 1, "first_wr_latency", cyc, acc_cyc + 1);
            else                  check(cyc == done_cyc + 1, "wr_after_done", cyc, done_cyc + 1);
            check(exp_w.size() > 0 && SPI_W_DATA == exp_w[0], "w_data", SPI_W_DATA,
                  exp_w.size() > 0 ? exp_w[0] : 8'hEE);
            if (exp_w.size() > 0) last_w = exp_w.pop_front();
            writes_seen++;
            wlog.push_back(SPI_W_DATA);
            strobe_cyc.push_back(cyc);
         end
         check(SPI_W_DATA == last_w, "w_data_hold", SPI_W_DATA, last_w);
         if (SPI_R_STB) begin
            check(cyc == done_cyc + 1, "rd_after_done", cyc, done_cyc + 1);
            reads_seen++;
            check(reads_seen <= exp_reads, "rd_count", reads_seen, exp_reads);
            strobe_cyc.push_back(cyc);
         end
         if (RSP_VALID) begin
            check(cyc == done_cyc + 1, "rsp_latency", cyc, done_cyc + 1);
            check(RSP_R1 == exp_r1 && RSP_TIMEOUT == exp_to, "rsp", {RSP_TIMEOUT, RSP_R1},
                  {exp_to, exp_r1});
            valid_seen++;
            last_r1 = exp_r1;
            last_to = exp_to;
         end else begin
            check(RSP_R1 == last_r1 && RSP_TIMEOUT == last_to, "rsp_hold",
                  {RSP_TIMEOUT, RSP_R1}, {last_to, last_r1});
         end
      end
   end

   // Build frame/response expectations from the command fields and the engine's read bytes.
   task automatic prep_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                           input int lat);
      logic [7:0] b;
      exp_w.delete();
      exp_w.push_back({2'b01, idx});
      for (int i = 3; i >= 0; i--) exp_w.push_back(8'((arg >> (8 * i)) & 32'hFF));
      exp_w.push_back({crc, 1'b1});
      exp_reads = 0; exp_r1 = 8'hFF; exp_to = 1'b1;
      for (int i = 0; i < int'(POLL_MAX); i++) begin
         b = (i < rd_src.size()) ? rd_src[i] : 8'hFF;
         exp_reads++;
         if (b < 8'h80) begin
            exp_r1 = b; exp_to = 1'b0;
            break;
         end
      end
      eng_rd = rd_src;
      eng_lat = lat;
      writes_seen = 0; reads_seen = 0; valid_seen = 0; busy_cycles = 0;
      wlog.delete();
      strobe_cyc.delete();
   endtask

   task automatic pulse_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
      @(posedge CLK50); #1;
      CMD_IDX = idx; CMD_ARG = arg; CMD_CRC = crc; CMD_STB = 1'b1;
      @(posedge CLK50); #1;
      CMD_STB = 1'b0;
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                          input int lat, input bit inject);
      prep_cmd(idx, arg, crc, lat);
      pulse_cmd(idx, arg, crc);
      for (int k = 0; k < 2000 && valid_seen == 0; k++) begin
         @(posedge CLK50); #1;
         CMD_STB = (inject && k == 3);
         if (inject && k == 3) begin
            CMD_IDX = 6'd17; CMD_ARG = 32'hFFFF_FFFF; CMD_CRC = 7'h7F;
         end
      end
      CMD_STB = 1'b0;
      if (valid_seen == 0) check(1'b0, "rsp_wait_timeout", 0, 1);
      repeat (3) @(posedge CLK50);
      #1;
      check(valid_seen == 1, "valid_once", valid_seen, 1);
      check(writes_seen == 6, "write_count", writes_seen, 6);
      check(reads_seen == exp_reads, "read_total", reads_seen, exp_reads);
      check(BUSY == 1'b0, "busy_dropped", BUSY, 0);
   endtask

   task automatic check_frame(input logic [47:0] f);
      check(wlog.size() == 6, "frame_len", wlog.size(), 6);
      for (int i = 0; i < 6; i++)
         check(wlog.size() > i && wlog[i] == f[47 - 8 * i -: 8], "frame_lit",
               wlog.size() > i ? wlog[i] : 8'hEE, f[47 - 8 * i -: 8]);
   endtask

   initial begin
      #2 RST = 1'b0;
      repeat (3) @(posedge CLK50);
      #1 RST = 1'b1;
      repeat (2) @(posedge CLK50);
      #1;
      check({BUSY, RSP_VALID, RSP_R1, SPI_W_STB, SPI_R_STB} == '0, "idle_after_reset",
            {BUSY, RSP_VALID, RSP_R1, SPI_W_STB, SPI_R_STB}, 0);

      // CMD0: one busy byte then R1 = 0x01
      rd_src = '{8'hFF, 8'h01};
      run_cmd(6'd0, 32'h0, 7'h4A, 2, 1'b0);
      check_frame(48'h40_00_00_00_00_95);
      check(reads_seen == 2, "cmd0_reads_lit", reads_seen, 2);
      check(RSP_R1 == 8'h01 && !RSP_TIMEOUT, "cmd0_r1_lit", {RSP_TIMEOUT, RSP_R1}, 9'h001);

      // CMD8: immediate R1
      rd_src = '{8'h01};
      run_cmd(6'd8, 32'h0000_01AA, 7'h43, 3, 1'b0);
      check_frame(48'h48_00_00_01_AA_87);
      check(reads_seen == 1, "cmd8_reads_lit", reads_seen, 1);
      check(RSP_R1 == 8'h01 && !RSP_TIMEOUT, "cmd8_r1_lit", {RSP_TIMEOUT, RSP_R1}, 9'h001);

      // Timeout: card never answers
      rd_src = {};
      run_cmd(6'd58, 32'h0, 7'h7E, 2, 1'b0);
      check(reads_seen == 8, "timeout_reads_lit", reads_seen, 8);
      check(RSP_R1 == 8'hFF && RSP_TIMEOUT, "timeout_rsp_lit", {RSP_TIMEOUT, RSP_R1}, 9'h1FF);

      // Stray CMD17 request while CMD0 is in flight
      rd_src = '{8'h00};
      run_cmd(6'd0, 32'h0, 7'h4A, 3, 1'b1);
      check_frame(48'h40_00_00_00_00_95);
      check(RSP_R1 == 8'h00 && !RSP_TIMEOUT, "inject_r1_lit", {RSP_TIMEOUT, RSP_R1}, 9'h000);

      // Reset while B3's transfer is outstanding
      rd_src = '{8'h01};
      prep_cmd(6'd0, 32'h0, 7'h4A, 4);
      pulse_cmd(6'd0, 32'h0, 7'h4A);
      for (int k = 0; k < 200 && writes_seen < 4; k++) @(posedge CLK50);
      check(writes_seen == 4, "reach_b3", writes_seen, 4);
      @(posedge CLK50);
      @(posedge CLK50); #2;
      RST = 1'b0;
      exp_w.delete();
      #1;
      check({BUSY, RSP_VALID, RSP_TIMEOUT, SPI_W_STB, SPI_R_STB, RSP_R1, SPI_W_DATA} == '0,
            "async_reset_lit", {BUSY, RSP_VALID, RSP_TIMEOUT, SPI_W_STB, SPI_R_STB, RSP_R1, SPI_W_DATA}, 0);
      repeat (3) @(posedge CLK50);
      #1 RST = 1'b1;
      repeat (10) @(posedge CLK50);
      #1;
      check(valid_seen == 0, "no_valid_after_reset", valid_seen, 0);
      rd_src = '{8'hFF, 8'h01};
      run_cmd(6'd0, 32'h0, 7'h4A, 2, 1'b0);
      check_frame(48'h40_00_00_00_00_95);

      // Zero-wait engine: strobe every 2 cycles, BUSY for 15 cycles
      rd_src = '{8'h01};
      run_cmd(6'd55, 32'h0, 7'h32, 1, 1'b0);
      check(busy_cycles == 15, "zero_wait_busy_lit", busy_cycles, 15);
      check(strobe_cyc.size() == 7, "zero_wait_strobes", strobe_cyc.size(), 7);
      for (int i = 1; i < strobe_cyc.size(); i++)
         check(strobe_cyc[i] - strobe_cyc[i-1] == 2, "zero_wait_gap",
               strobe_cyc[i] - strobe_cyc[i-1], 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
